spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter_if.sv | 36 +++
 rtl/spi_txn_arbiter.sv | 151 +++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_arbiter_if.sv
// Requester/engine bundle for the SPI transaction arbiter.
//   master : arbiter side (samples requests and engine status, drives grants, pulses, engine strobe)
//   slave  : requesters plus SPI byte engine side
// Signals:
//   req[1:0], len0/len1[3:0], tx_data0/tx_data1[7:0]  requester inputs
//   grant, tx_next, rx_valid, done, err [1:0]          per-requester outputs
//   rx_data[7:0]                                       last received byte
//   eng_data_in[7:0], eng_ready_send                   engine launch
//   eng_data_out[7:0], eng_busy                        engine status
interface spi_txn_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] grant;
  logic [1:0] tx_next;
  logic [7:0] rx_data;
  logic [1:0] rx_valid;
  logic [1:0] done;
  logic [1:0] err;
  logic [7:0] eng_data_in;
  logic       eng_ready_send;
  logic [7:0] eng_data_out;
  logic       eng_busy;

  modport master (
    input  req, len0, len1, tx_data0, tx_data1, eng_data_out, eng_busy,
    output grant, tx_next, rx_data, rx_valid, done, err, eng_data_in, eng_ready_send
  );

  modport slave (
    output req, len0, len1, tx_data0, tx_data1, eng_data_out, eng_busy,
    input  grant, tx_next, rx_data, rx_valid, done, err, eng_data_in, eng_ready_send
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI byte engine. The granted
// requester owns the engine for len+1 bytes; each byte is launched, its completion awaited,
// the received byte returned, then an inter-byte gap is observed.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : spi_txn_arbiter_if.master (requester handshake and engine signals)
module spi_txn_arbiter #(
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_txn_arbiter_if.master   bus
);

  localparam int unsigned TimerW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int unsigned GapW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitStart,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;          // requester with priority at next arbitration
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        remaining_q, remaining_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [1:0]        rx_valid_q, rx_valid_d;

  logic launch;
  logic done_p;
  logic err_p;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = '0;
    launch      = 1'b0;
    done_p      = 1'b0;
    err_p       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req != 2'b00) begin
          // Preferred requester wins if asking, otherwise the other one must be.
          owner_d     = bus.req[rr_q] ? rr_q : ~rr_q;
          grant_d     = owner_d ? 2'b10 : 2'b01;
          remaining_d = owner_d ? bus.len1 : bus.len0;
          state_d     = StLaunch;
        end
      end
      StLaunch: begin
        // Never strobe into a busy engine; wait here until it frees up.
        if (!bus.eng_busy) begin
          launch  = 1'b1;
          timer_d = '0;
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        if (bus.eng_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerW'(START_TIMEOUT - 1)) begin
          err_p   = 1'b1;
          grant_d = '0;
          rr_d    = ~owner_q;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.eng_busy) begin
          rx_data_d  = bus.eng_data_out;
          rx_valid_d = grant_q;
          gap_d      = '0;
          state_d    = StGap;
        end
      end
      StGap: begin
        // One decision cycle plus GAP_CYCLES idle cycles.
        if (gap_q == GapW'(GAP_CYCLES)) begin
          if (remaining_q == 4'd0) begin
            done_p  = 1'b1;
            grant_d = '0;
            rr_d    = ~owner_q;
            state_d = StIdle;
          end else begin
            remaining_d = remaining_q - 4'd1;
            state_d     = StLaunch;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      grant_q     <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  // Pulses are decoded from current state, so mask them during the reset cycle itself.
  logic launch_go;
  assign launch_go = launch & ~rst;

  assign bus.eng_ready_send = launch_go;
  assign bus.eng_data_in    = launch_go ? (owner_q ? bus.tx_data1 : bus.tx_data0) : 8'h00;
  assign bus.tx_next        = launch_go ? grant_q : 2'b00;
  assign bus.done           = (done_p & ~rst) ? grant_q : 2'b00;
  assign bus.err            = (err_p & ~rst) ? grant_q : 2'b00;
  assign bus.grant          = grant_q;
  assign bus.rx_data        = rx_data_q;
  assign bus.rx_valid       = rx_valid_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized self-checking bench for spi_txn_arbiter with a transaction-level reference model.
module tb_spi_txn_arbiter;

  localparam int StartTimeout = 16;
  localparam int GapCycles    = 2;

  logic clk;
  logic rst;

  spi_txn_arbiter_if bus ();

  spi_txn_arbiter #(
    .START_TIMEOUT (StartTimeout),
    .GAP_CYCLES    (GapCycles)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int o);
    return (o != 0) ? 2'b10 : 2'b01;
  endfunction

  // Engine / requester behaviour controls
  int         eng_never   = 0;   // engine ignores strobes
  int         hold_mode   = 0;   // engine re-asserts busy right after each byte
  int         force_dur   = 0;   // 0 = random busy length
  int         force_resp  = -1;  // -1 = random response byte
  logic [7:0] rx_exp_q[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Reference model state
  int         cyc = 0;
  int         rr = 0;
  int         m_active = 0;
  int         m_owner = 0;
  int         m_len = 0;
  int         m_strobes = 0;
  int         m_rxv = 0;
  int         arb_pending = 0;
  int         arb_owner = 0;
  int         arb_len = 0;
  int         last_strobe_cyc = 0;
  int         last_rxv_cyc = 0;
  int         rst_prev = 0;
  int         gap_check_en = 1;
  int         ev_cnt = 0;
  int         done_cnt[2] = '{0, 0};
  int         err_cnt[2] = '{0, 0};
  logic [7:0] last_rx = 8'h00;
  int         owners_q[$];
  logic [7:0] launched_q[$];

  // SPI byte engine model
  initial begin
    logic       s;
    int         cnt;
    int         push;
    int         rehold;
    logic [7:0] resp;
    cnt = 0; push = 0; rehold = 0; resp = 8'h00;
    bus.eng_busy = 1'b0;
    bus.eng_data_out = 8'h00;
    forever begin
      @(negedge clk);
      s = bus.eng_ready_send;
      @(posedge clk);
      #1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eng_busy = 1'b0;
          if (push != 0) begin
            bus.eng_data_out = resp;
            rx_exp_q.push_back(resp);
            if (hold_mode != 0) rehold = 1;
          end
        end
      end else if (rehold != 0) begin
        rehold = 0;
        bus.eng_busy = 1'b1;
        cnt = 6;
        push = 0;
      end else if (s && eng_never == 0) begin
        bus.eng_busy = 1'b1;
        cnt = (force_dur > 0) ? force_dur : int'($urandom_range(1, 5));
        resp = (force_resp >= 0) ? 8'(force_resp) : 8'($urandom);
        push = 1;
      end
    end
  end

  // Requesters: present the next byte after each tx_next
  initial begin
    logic [1:0] tn;
    forever begin
      @(negedge clk);
      tn = bus.tx_next;
      @(posedge clk);
      #1;
      if (tn[0]) bus.tx_data0 = (q0.size() > 0) ? q0.pop_front() : 8'($urandom);
      if (tn[1]) bus.tx_data1 = (q1.size() > 0) ? q1.pop_front() : 8'($urandom);
    end
  end

  // Monitor + reference model
  initial begin
    int         idle_now;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check_eq("rst_no_strobe", 32'(bus.eng_ready_send), 0);
        check_eq("rst_no_done_err", 32'({bus.done, bus.err}), 0);
        m_active = 0; arb_pending = 0; rr = 0; last_rx = 8'h00; rst_prev = 1;
      end else begin
        if (rst_prev != 0) begin
          check_eq("post_rst_grant", 32'(bus.grant), 0);
          check_eq("post_rst_pulses", 32'({bus.tx_next, bus.rx_valid, bus.done, bus.err}), 0);
          check_eq("post_rst_rx_data", 32'(bus.rx_data), 0);
          check_eq("post_rst_eng", 32'({bus.eng_ready_send, bus.eng_data_in}), 0);
        end
        rst_prev = 0;
        idle_now = 0;
        if (arb_pending != 0) begin
          m_active = 1; m_owner = arb_owner; m_len = arb_len;
          m_strobes = 0; m_rxv = 0; arb_pending = 0;
          owners_q.push_back(arb_owner);
          launched_q.delete();
        end else if (m_active == 0) begin
          check_eq("grant_idle", 32'(bus.grant), 0);
          idle_now = 1;
        end
        if (m_active != 0) check_eq("grant_held", 32'(bus.grant), 32'(oh(m_owner)));
        check_eq("grant_onehot0", 32'($countones(bus.grant) <= 1), 1);
        check_eq("nonowner_quiet",
                 32'((bus.tx_next | bus.rx_valid | bus.done | bus.err) & ~bus.grant), 0);
        if (bus.eng_busy) check_eq("strobe_while_busy", 32'(bus.eng_ready_send), 0);

        if (bus.eng_ready_send) begin
          exp_b = (m_owner != 0) ? bus.tx_data1 : bus.tx_data0;
          check_eq("strobe_owned", 32'(m_active), 1);
          check_eq("eng_data_in", 32'(bus.eng_data_in), 32'(exp_b));
          check_eq("tx_next", 32'(bus.tx_next), 32'(oh(m_owner)));
          if (gap_check_en != 0 && m_strobes > 0)
            check_eq("byte_gap", 32'(cyc - last_rxv_cyc), 32'(GapCycles + 1));
          m_strobes++;
          last_strobe_cyc = cyc;
          launched_q.push_back(bus.eng_data_in);
        end else begin
          check_eq("tx_next_idle", 32'(bus.tx_next), 0);
        end

        if (bus.rx_valid != 2'b00) begin
          check_eq("rx_expected_avail", 32'(rx_exp_q.size() > 0), 1);
          if (rx_exp_q.size() > 0) begin
            exp_b = rx_exp_q.pop_front();
            check_eq("rx_data", 32'(bus.rx_data), 32'(exp_b));
            last_rx = exp_b;
          end
          check_eq("rx_valid_owner", 32'(bus.rx_valid), 32'(oh(m_owner)));
          m_rxv++;
          last_rxv_cyc = cyc;
        end else begin
          check_eq("rx_hold", 32'(bus.rx_data), 32'(last_rx));
        end

        if (bus.done != 2'b00) begin
          check_eq("done_owner", 32'(bus.done), 32'(oh(m_owner)));
          check_eq("done_strobes", 32'(m_strobes), 32'(m_len + 1));
          check_eq("done_rxv", 32'(m_rxv), 32'(m_len + 1));
          check_eq("done_timing", 32'(cyc - last_rxv_cyc), 32'(GapCycles));
          done_cnt[m_owner]++;
          ev_cnt++;
          rr = 1 - m_owner;
          m_active = 0;
        end
        if (bus.err != 2'b00) begin
          check_eq("err_owner", 32'(bus.err), 32'(oh(m_owner)));
          check_eq("err_timing", 32'(cyc - last_strobe_cyc), 32'(StartTimeout));
          check_eq("err_no_rxv", 32'(m_rxv), 32'(m_strobes - 1));
          err_cnt[m_owner]++;
          ev_cnt++;
          rr = 1 - m_owner;
          m_active = 0;
        end

        if (idle_now != 0 && bus.req != 2'b00) begin
          arb_pending = 1;
          arb_owner = bus.req[rr] ? rr : 1 - rr;
          arb_len = (arb_owner != 0) ? int'(bus.len1) : int'(bus.len0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input logic [1:0] pattern, input int budget);
    int e0;
    e0 = ev_cnt;
    bus.req = pattern;
    for (int i = 0; i < budget && bus.grant == 2'b00; i++) step();
    bus.req = 2'b00;
    for (int i = 0; i < budget && ev_cnt == e0; i++) step();
    check_eq("txn_finished", 32'(ev_cnt != e0), 1);
  endtask

  task automatic wait_engine_idle(input int budget);
    for (int i = 0; i < budget && bus.eng_busy; i++) step();
    check_eq("engine_idle", 32'(bus.eng_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int d0;
    int r0;
    rst = 1'b1;
    bus.req = 2'b11;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    bus.tx_data0 = 8'h00;
    bus.tx_data1 = 8'h00;
    repeat (3) step();
    rst = 1'b0;

    // Contention from reset: both requesting, single-byte transactions
    e0 = ev_cnt;
    for (int i = 0; i < 600 && ev_cnt < e0 + 4; i++) step();
    bus.req = 2'b00;
    check_eq("rr_count", 32'(owners_q.size()), 4);
    for (int i = 0; i < 4 && i < owners_q.size(); i++)
      check_eq("rr_order", 32'(owners_q[i]), 32'(i % 2));
    wait_engine_idle(50);
    step();

    // Single byte A5 -> 3C, engine busy 20 cycles
    force_dur = 20; force_resp = 8'h3C;
    bus.len0 = 4'd0; bus.tx_data0 = 8'hA5;
    d0 = done_cnt[0];
    run_txn(2'b01, 200);
    check_eq("single_done", 32'(done_cnt[0] - d0), 1);
    check_eq("single_launches", 32'(launched_q.size()), 1);
    if (launched_q.size() > 0) check_eq("single_tx_byte", 32'(launched_q[0]), 32'h A5);
    check_eq("single_rx_data", 32'(bus.rx_data), 32'h3C);
    force_dur = 0; force_resp = -1;

    // Multi-byte 11, 22, 33 on requester 1
    bus.len1 = 4'd2; bus.tx_data1 = 8'h11;
    q1.push_back(8'h22); q1.push_back(8'h33);
    d0 = done_cnt[1];
    run_txn(2'b10, 300);
    check_eq("multi_done", 32'(done_cnt[1] - d0), 1);
    check_eq("multi_launches", 32'(launched_q.size()), 3);
    for (int i = 0; i < 3 && i < launched_q.size(); i++)
      check_eq("multi_tx_byte", 32'(launched_q[i]), 32'(8'h11 * (i + 1)));

    // Start timeout: engine never goes busy
    eng_never = 1;
    bus.len0 = 4'd2;
    d0 = done_cnt[0]; r0 = err_cnt[0];
    run_txn(2'b01, 200);
    check_eq("timeout_err", 32'(err_cnt[0] - r0), 1);
    check_eq("timeout_no_done", 32'(done_cnt[0] - d0), 0);
    check_eq("timeout_no_rx", 32'(rx_exp_q.size()), 0);
    eng_never = 0;
    step();

    // Busy already high when LAUNCH is entered
    hold_mode = 1; gap_check_en = 0;
    bus.len0 = 4'd2;
    d0 = done_cnt[0];
    run_txn(2'b01, 400);
    check_eq("hold_done", 32'(done_cnt[0] - d0), 1);
    check_eq("hold_launches", 32'(launched_q.size()), 3);
    hold_mode = 0;
    wait_engine_idle(50);
    gap_check_en = 1;

    // Reset during WAIT_DONE of byte 2 of 4
    force_dur = 8;
    bus.len0 = 4'd3;
    bus.req = 2'b01;
    for (int i = 0; i < 300 && !(m_strobes == 2 && m_active != 0 && bus.eng_busy); i++) step();
    check_eq("reset_point_reached", 32'(m_strobes == 2 && bus.eng_busy), 1);
    bus.req = 2'b00;
    step();
    d0 = done_cnt[0] + done_cnt[1]; r0 = err_cnt[0] + err_cnt[1];
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_engine_idle(50);
    rx_exp_q.delete();
    check_eq("reset_no_done", 32'(done_cnt[0] + done_cnt[1] - d0), 0);
    check_eq("reset_no_err", 32'(err_cnt[0] + err_cnt[1] - r0), 0);
    force_dur = 0;
    bus.len1 = 4'd1;
    d0 = done_cnt[1];
    run_txn(2'b10, 300);
    check_eq("post_reset_served", 32'(done_cnt[1] - d0), 1);
    check_eq("post_reset_owner", 32'(owners_q[owners_q.size() - 1]), 1);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      bus.req  = 2'($urandom_range(0, 3));
      bus.len0 = 4'($urandom_range(0, 3));
      bus.len1 = 4'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) step();
    end
    bus.req = 2'b00;
    for (int i = 0; i < 3000 && (m_active != 0 || arb_pending != 0); i++) step();
    check_eq("drain_idle", 32'(m_active != 0 || arb_pending != 0), 0);
    check_eq("drain_grant", 32'(bus.grant), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
